// File: rtl/pcm_pkg.sv
// pcm_pkg: shared types and widths for the PCM read scheduler.
//   pcm_sched_state_t : scheduler FSM state encoding
//   PCM_ADDR_W        : SDRAM word-address width
//   PCM_DATA_W        : PCM sample width
package pcm_pkg;

   localparam int PCM_ADDR_W = 25;
   localparam int PCM_DATA_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_AC,
      S_DRAIN,
      S_DONE
   } pcm_sched_state_t;

endpackage

// File: rtl/pcm_sync_fifo.sv
// pcm_sync_fifo: synchronous FIFO used as the PCM prefetch buffer.
// Ports:
//   clk       in   clock
//   clear_n   in   synchronous active-low clear (pointers and count)
//   push      in   write push_data (ignored when full unless popping)
//   push_data in   WIDTH write data
//   pop       in   drop head entry (ignored when empty)
//   head      out  WIDTH oldest entry, valid when count != 0
//   count     out  number of stored entries, 0..DEPTH
module pcm_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     clear_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is legal when a pop retires the head in the
   // same cycle; with full pointers equal, the head is read before the write.
   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/pcm_stream_sched.sv
// pcm_stream_sched: fetches a block of PCM words from the SDRAM arbiter's
// audio read port into a prefetch FIFO and serves one word per I2S request.
// Optional build macro PCM_LOOP_EN adds the 'loop' input for continuous
// replay of the block.
// Ports:
//   clk, reset (sync, active low)
//   start, base_addr, length          playback command (accepted in IDLE)
//   loop                              replay block at its end (PCM_LOOP_EN only)
//   sdram_wait, sdram_rd, sdram_addr  read request handshake
//   sdram_ac, sdram_data              read acknowledge and data
//   sample_req                        I2S word request
//   sample_data, sample_valid         word delivered one cycle after request
//   busy, done, underrun              status
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start
// S_ISSUE   | ready to request next word once FIFO space and grant exist
// S_WAIT_AC | read outstanding, waiting for acknowledge
// S_DRAIN   | all words fetched, waiting for FIFO to be consumed
// S_DONE    | done pulse, back to idle
module pcm_stream_sched
   import pcm_pkg::*;
#(
   parameter int ADDR_W     = PCM_ADDR_W,
   parameter int DATA_W     = PCM_DATA_W,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef PCM_LOOP_EN
   input  logic              loop,
`endif
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic              sdram_wait,
   output logic              sdram_rd,
   output logic [ADDR_W-1:0] sdram_addr,
   input  logic              sdram_ac,
   input  logic [DATA_W-1:0] sdram_data,
   input  logic              sample_req,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   pcm_sched_state_t  state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] remaining_q;
   logic              rd_q;
   logic              busy_q;
   logic              done_q;
   logic              underrun_q;
   logic              sample_valid_q;
   logic [DATA_W-1:0] sample_data_q;

   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic              last_word;
   logic              loop_now;

`ifdef PCM_LOOP_EN
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   assign loop_now = loop;
`else
   assign loop_now = 1'b0;
`endif

   assign fifo_empty = (fifo_count == '0);
   assign fifo_push  = (state_q == S_WAIT_AC) && sdram_ac;
   assign fifo_pop   = sample_req && !fifo_empty;
   assign last_word  = (remaining_q == ADDR_W'(1));

   // The arbiter may withdraw its grant at any time; the request must fall
   // in that same cycle, so the registered request is gated by sdram_wait.
   assign sdram_rd     = rd_q && !sdram_wait;
   assign sdram_addr   = addr_q;
   assign sample_data  = sample_data_q;
   assign sample_valid = sample_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign underrun     = underrun_q;

   pcm_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .clear_n   (reset),
      .push      (fifo_push),
      .push_data (sdram_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         remaining_q    <= '0;
         rd_q           <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         underrun_q     <= 1'b0;
         sample_valid_q <= 1'b0;
         sample_data_q  <= '0;
`ifdef PCM_LOOP_EN
         base_q         <= '0;
         len_q          <= '0;
`endif
      end else begin
         done_q         <= 1'b0;
         underrun_q     <= 1'b0;
         sample_valid_q <= sample_req;

         if (sample_req) begin
            if (!fifo_empty) begin
               sample_data_q <= fifo_head;
            end else begin
               sample_data_q <= '0;
               underrun_q    <= busy_q;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q      <= base_addr;
                  remaining_q <= length;
`ifdef PCM_LOOP_EN
                  base_q      <= base_addr;
                  len_q       <= length;
`endif
                  if (length == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                     busy_q  <= 1'b1;
                  end
               end
            end
            // Only one read is ever outstanding and it only exists in
            // S_WAIT_AC, so here the FIFO count alone bounds the fill.
            S_ISSUE: begin
               if (!sdram_wait && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
                  rd_q    <= 1'b1;
                  state_q <= S_WAIT_AC;
               end
            end
            S_WAIT_AC: begin
               if (sdram_ac) begin
                  rd_q        <= 1'b0;
                  addr_q      <= addr_q + ADDR_W'(1);
                  remaining_q <= remaining_q - ADDR_W'(1);
                  if (!last_word) begin
                     state_q <= S_ISSUE;
                  end else if (loop_now) begin
`ifdef PCM_LOOP_EN
                     addr_q      <= base_q;
                     remaining_q <= len_q;
`endif
                     state_q <= S_ISSUE;
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end else if (sdram_wait) begin
                  // Grant lost before acknowledge: retry the same address.
                  rd_q    <= 1'b0;
                  state_q <= S_ISSUE;
               end
            end
            S_DRAIN: begin
               if (fifo_empty) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcm_stream_sched.sv
// tb_pcm_stream_sched: directed self-checking bench for pcm_stream_sched.
// A simple SDRAM responder acknowledges each read two cycles after it is
// seen and returns word_of(addr); tasks drive commands and I2S requests.
module tb_pcm_stream_sched;

   localparam int AW = 25;
   localparam int DW = 16;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] length;
   logic          sdram_wait;
   logic          sdram_rd;
   logic [AW-1:0] sdram_addr;
   logic          sdram_ac;
   logic [DW-1:0] sdram_data;
   logic          sample_req;
   logic [DW-1:0] sample_data;
   logic          sample_valid;
   logic          busy;
   logic          done;
   logic          underrun;
`ifdef PCM_LOOP_EN
   logic          loop;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic          auto_ack;
   int            lat_cnt;
   logic [AW-1:0] ack_log[$];
   int            done_cnt;
   int            under_cnt;
   int            busy_cnt;
   int            rd_cnt;
   int            wait_viol;

   pcm_stream_sched dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
`ifdef PCM_LOOP_EN
      .loop         (loop),
`endif
      .base_addr    (base_addr),
      .length       (length),
      .sdram_wait   (sdram_wait),
      .sdram_rd     (sdram_rd),
      .sdram_addr   (sdram_addr),
      .sdram_ac     (sdram_ac),
      .sdram_data   (sdram_data),
      .sample_req   (sample_req),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done),
      .underrun     (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   // SDRAM responder: ack on the second negedge that sees the request.
   always @(negedge clk) begin
      if (auto_ack) begin
         sdram_ac = 1'b0;
         if (sdram_rd) begin
            if (lat_cnt == 1) begin
               sdram_ac   = 1'b1;
               sdram_data = word_of(sdram_addr);
               ack_log.push_back(sdram_addr);
               lat_cnt    = 0;
            end else begin
               lat_cnt++;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (done)                   done_cnt++;
      if (underrun)               under_cnt++;
      if (busy)                   busy_cnt++;
      if (sdram_rd)               rd_cnt++;
      if (sdram_rd && sdram_wait) wait_viol++;
   end

   task automatic clear_counts();
      done_cnt  = 0;
      under_cnt = 0;
      busy_cnt  = 0;
      rd_cnt    = 0;
      wait_viol = 0;
      ack_log.delete();
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset      = 1'b0;
      start      = 1'b0;
      sample_req = 1'b0;
      sdram_wait = 1'b0;
      sdram_ac   = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      lat_cnt = 0;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = b;
      length    = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Returns #1 after the edge where sample_valid/sample_data are presented.
   task automatic pulse_req();
      @(posedge clk); #1;
      sample_req = 1'b1;
      @(posedge clk); #1;
      sample_req = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({sdram_rd, busy, done, underrun, sample_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {sdram_rd, busy, done, underrun, sample_valid});
      end
      n_checks++;
      if (sample_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0000", sample_data);
      end
      n_checks++;
      if (sdram_addr !== 25'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h expected 0", sdram_addr);
      end
   endtask

   task automatic test_basic();
      clear_counts();
      do_start(25'h100, 25'd4);
      for (int i = 0; i < 4; i++) begin
         repeat (9) @(posedge clk);
         pulse_req();
         n_checks++;
         if (sample_valid !== 1'b1 || sample_data !== word_of(25'h100 + AW'(i))) begin
            n_fail++;
            $display("FAIL basic_word%0d: got v=%b d=%h expected v=1 d=%h",
                     i, sample_valid, sample_data, word_of(25'h100 + AW'(i)));
         end
      end
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (sample_valid !== 1'b0 || sample_data !== word_of(25'h103)) begin
         n_fail++;
         $display("FAIL basic_hold: got v=%b d=%h expected v=0 d=%h",
                  sample_valid, sample_data, word_of(25'h103));
      end
      n_checks++;
      if (ack_log.size() != 4) begin
         n_fail++;
         $display("FAIL basic_nreads: got %0d expected 4", ack_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ack_log[i] !== 25'h100 + AW'(i)) begin
               n_fail++;
               $display("FAIL basic_addr%0d: got %h expected %h",
                        i, ack_log[i], 25'h100 + AW'(i));
            end
         end
      end
      n_checks++;
      if (done_cnt != 1 || under_cnt != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_status: got done=%0d under=%0d busy=%b expected 1 0 0",
                  done_cnt, under_cnt, busy);
      end
   endtask

   task automatic test_zero_len();
      clear_counts();
      do_start(25'h200, 25'd0);
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL zero_done: got %0d pulses expected 1", done_cnt);
      end
      n_checks++;
      if (rd_cnt != 0 || busy_cnt > 1) begin
         n_fail++;
         $display("FAIL zero_rd_busy: got rd=%0d busy=%0d expected rd=0 busy<=1",
                  rd_cnt, busy_cnt);
      end
   endtask

   // sample_data still holds a nonzero word from the previous block here.
   task automatic test_underrun_busy();
      clear_counts();
      auto_ack = 1'b0;
      do_start(25'h500, 25'd2);
      pulse_req();
      n_checks++;
      if (sample_valid !== 1'b1 || sample_data !== 16'h0000 || underrun !== 1'b1) begin
         n_fail++;
         $display("FAIL underrun_busy: got v=%b d=%h u=%b expected v=1 d=0000 u=1",
                  sample_valid, sample_data, underrun);
      end
      apply_reset();
      auto_ack = 1'b1;
   endtask

   task automatic test_wait();
      clear_counts();
      do_start(25'h300, 25'd2);
      @(posedge clk); #1;
      n_checks++;
      if (sdram_rd !== 1'b1 || sdram_addr !== 25'h300) begin
         n_fail++;
         $display("FAIL wait_pre_rd: got rd=%b a=%h expected rd=1 a=300",
                  sdram_rd, sdram_addr);
      end
      sdram_wait = 1'b1;
      #1;
      n_checks++;
      if (sdram_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_drop: got rd=%b expected 0", sdram_rd);
      end
      repeat (20) @(posedge clk);
      #1 sdram_wait = 1'b0;
      repeat (15) @(posedge clk);
      pulse_req();
      n_checks++;
      if (sample_data !== word_of(25'h300)) begin
         n_fail++;
         $display("FAIL wait_word0: got %h expected %h", sample_data, word_of(25'h300));
      end
      pulse_req();
      n_checks++;
      if (sample_data !== word_of(25'h301)) begin
         n_fail++;
         $display("FAIL wait_word1: got %h expected %h", sample_data, word_of(25'h301));
      end
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (ack_log.size() != 2 || ack_log[0] !== 25'h300 || ack_log[1] !== 25'h301) begin
         n_fail++;
         $display("FAIL wait_addrs: got n=%0d expected 300,301", ack_log.size());
      end
      n_checks++;
      if (wait_viol != 0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL wait_status: got viol=%0d done=%0d expected 0 1",
                  wait_viol, done_cnt);
      end
   endtask

   task automatic test_backpressure();
      clear_counts();
      do_start(25'h400, 25'd32);
      repeat (60) @(posedge clk); #1;
      n_checks++;
      if (ack_log.size() != 8 || sdram_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_fill: got reads=%0d rd=%b expected 8 0",
                  ack_log.size(), sdram_rd);
      end
      pulse_req();
      n_checks++;
      if (sample_data !== word_of(25'h400)) begin
         n_fail++;
         $display("FAIL bp_word0: got %h expected %h", sample_data, word_of(25'h400));
      end
      repeat (10) @(posedge clk); #1;
      n_checks++;
      if (ack_log.size() != 9 || ack_log[ack_log.size()-1] !== 25'h408) begin
         n_fail++;
         $display("FAIL bp_refill: got reads=%0d expected 9 ending at 408",
                  ack_log.size());
      end
      apply_reset();
   endtask

   task automatic test_reset_mid();
      clear_counts();
      auto_ack = 1'b0;
      do_start(25'h600, 25'd3);
      repeat (2) @(posedge clk);
      apply_reset();
      sdram_ac   = 1'b1;
      sdram_data = 16'hDEAD;
      @(posedge clk); #1;
      sdram_ac = 1'b0;
      n_checks++;
      if ({sdram_rd, busy, done, underrun, sample_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid_flags: got %b expected 00000",
                  {sdram_rd, busy, done, underrun, sample_valid});
      end
      pulse_req();
      n_checks++;
      if (sample_data !== 16'h0000 || underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_late_ac: got d=%h u=%b expected d=0000 u=0",
                  sample_data, underrun);
      end
      auto_ack = 1'b1;
      clear_counts();
      do_start(25'h700, 25'd2);
      repeat (15) @(posedge clk);
      pulse_req();
      n_checks++;
      if (sample_data !== word_of(25'h700)) begin
         n_fail++;
         $display("FAIL rstmid_word0: got %h expected %h", sample_data, word_of(25'h700));
      end
      pulse_req();
      n_checks++;
      if (sample_data !== word_of(25'h701)) begin
         n_fail++;
         $display("FAIL rstmid_word1: got %h expected %h", sample_data, word_of(25'h701));
      end
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_done: got done=%0d busy=%b expected 1 0", done_cnt, busy);
      end
      pulse_req();
      n_checks++;
      if (sample_valid !== 1'b1 || sample_data !== 16'h0000 || underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_silence: got v=%b d=%h u=%b expected v=1 d=0000 u=0",
                  sample_valid, sample_data, underrun);
      end
   endtask

`ifdef PCM_LOOP_EN
   task automatic test_loop();
      clear_counts();
      loop = 1'b1;
      do_start(25'h100, 25'd3);
      repeat (40) @(posedge clk); #1;
      n_checks++;
      if (ack_log.size() < 4 || ack_log[0] !== 25'h100 || ack_log[1] !== 25'h101 ||
          ack_log[2] !== 25'h102 || ack_log[3] !== 25'h100) begin
         n_fail++;
         $display("FAIL loop_addrs: got n=%0d expected 100,101,102,100", ack_log.size());
      end
      n_checks++;
      if (done_cnt != 0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL loop_nodone: got done=%0d busy=%b expected 0 1", done_cnt, busy);
      end
      loop = 1'b0;
      apply_reset();
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      length     = '0;
      sdram_wait = 1'b0;
      sdram_ac   = 1'b0;
      sdram_data = '0;
      sample_req = 1'b0;
      auto_ack   = 1'b1;
      lat_cnt    = 0;
`ifdef PCM_LOOP_EN
      loop       = 1'b0;
`endif
      clear_counts();

      test_reset();
      test_basic();
      test_zero_len();
      test_underrun_busy();
      test_wait();
      test_backpressure();
      test_reset_mid();
`ifdef PCM_LOOP_EN
      test_loop();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
